// File: rtl/mem_arb_pkg.sv
// Shared types for the icache/dcache memory arbiter.
// Holds FSM state, requester ids and line geometry.
package mem_arb_pkg;

   typedef enum logic [1:0] {IDLE, CMD, RESP} arb_state_t;

   typedef enum logic {REQ_IC, REQ_DC} req_id_t;

   localparam int LINE_BYTES    = 16;
   localparam int LINE_OFF_BITS = 4;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker (combinational).
// Ports: req[0]=icache, req[1]=dcache, last = previous winner, grant = pick.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  req_id_t    last,
   output req_id_t    grant
);

   always_comb begin
      grant = REQ_IC;
      unique case (1'b1)
         req[0] && req[1]:
            grant = (last == REQ_IC) ? REQ_DC : REQ_IC;
         req[1] && !req[0]:
            grant = REQ_DC;
         default:
            grant = REQ_IC;
      endcase
   end

endmodule

// File: rtl/icache_dcache_mem_arbiter.sv
// Shares one line-wide memory port between icache refill and dcache
// refill/writeback, one transaction at a time, round-robin on contention.
// Ports: ic_* icache read side, dc_* dcache read/write side,
//        mem_* registered command port with waitrequest and rdvalid.
module icache_dcache_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 128
)(
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [ADDR_WIDTH-1:0] ic_addr,
   input  logic                  ic_rd,
   output logic [DATA_WIDTH-1:0] ic_rdata,
   output logic                  ic_waitrequest,
   input  logic [ADDR_WIDTH-1:0] dc_addr,
   input  logic                  dc_rd,
   input  logic                  dc_wr,
   input  logic [DATA_WIDTH-1:0] dc_wdata,
   output logic [DATA_WIDTH-1:0] dc_rdata,
   output logic                  dc_waitrequest,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_rd,
   output logic                  mem_wr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_waitrequest,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_rdvalid
);

   localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
      ADDR_WIDTH'(LINE_BYTES - 1);

   arb_state_t            state;
   arb_state_t            state_nxt;
   req_id_t               owner;
   req_id_t               last_grant;
   req_id_t               grant;
   logic                  aborted;
   logic                  ic_req;
   logic                  dc_req;
   logic                  any_req;
   logic                  owner_req;
   logic                  grant_wr;
   logic                  done;
   logic                  deliver;
   logic [ADDR_WIDTH-1:0] grant_addr;

   assign ic_req    = ic_rd;
   assign dc_req    = dc_rd | dc_wr;
   assign any_req   = ic_req | dc_req;
   assign owner_req = (owner == REQ_IC) ? ic_req : dc_req;

   rr_arb2 u_rr (
      .req   ({dc_req, ic_req}),
      .last  (last_grant),
      .grant (grant)
   );

   // dc_rd together with dc_wr is resolved as a write
   assign grant_addr = (grant == REQ_DC) ? dc_addr : ic_addr;
   assign grant_wr   = (grant == REQ_DC) && dc_wr;

   // Read data is a pure pass-through; waitrequest qualifies it
   assign ic_rdata = mem_rdata;
   assign dc_rdata = mem_rdata;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:
            if (any_req) state_nxt = CMD;
         CMD:
            if (!mem_waitrequest) state_nxt = mem_wr ? IDLE : RESP;
         RESP:
            if (mem_rdvalid) state_nxt = IDLE;
         default:
            state_nxt = IDLE;
      endcase
   end

   // Completion is hidden if the owner ever dropped its request
   // during this transaction (fetch redirect): data is discarded.
   always_comb begin
      done = 1'b0;
      unique case (state)
         CMD    : done = mem_wr && !mem_waitrequest;
         RESP   : done = mem_rdvalid;
         default: done = 1'b0;
      endcase
      deliver        = done && owner_req && !aborted;
      ic_waitrequest = !(deliver && owner == REQ_IC);
      dc_waitrequest = !(deliver && owner == REQ_DC);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mem_rd     <= 1'b0;
         mem_wr     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         owner      <= REQ_IC;
         last_grant <= REQ_IC;
         aborted    <= 1'b0;
      end else begin
         unique case (state)
            IDLE:
               if (any_req) begin
                  mem_addr   <= grant_addr & ~LINE_MASK;
                  mem_rd     <= !grant_wr;
                  mem_wr     <= grant_wr;
                  owner      <= grant;
                  last_grant <= grant;
                  aborted    <= 1'b0;
                  if (grant_wr) mem_wdata <= dc_wdata;
               end
            CMD: begin
               if (!mem_waitrequest) begin
                  mem_rd <= 1'b0;
                  mem_wr <= 1'b0;
               end
               if (!owner_req) aborted <= 1'b1;
            end
            RESP:
               if (!owner_req) aborted <= 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_icache_dcache_mem_arbiter.sv
// Self-checking bench for icache_dcache_mem_arbiter: directed scenarios
// plus a randomized soak against a transaction-level reference model.
module tb_icache_dcache_mem_arbiter;
   import mem_arb_pkg::*;

   localparam int AW = 32;
   localparam int DW = 128;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic [AW-1:0] ic_addr, dc_addr, mem_addr;
   logic          ic_rd, dc_rd, dc_wr;
   logic          ic_waitrequest, dc_waitrequest;
   logic          mem_rd, mem_wr, mem_waitrequest, mem_rdvalid;
   logic [DW-1:0] ic_rdata, dc_rdata, dc_wdata, mem_wdata, mem_rdata;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   icache_dcache_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .ic_addr         (ic_addr),
      .ic_rd           (ic_rd),
      .ic_rdata        (ic_rdata),
      .ic_waitrequest  (ic_waitrequest),
      .dc_addr         (dc_addr),
      .dc_rd           (dc_rd),
      .dc_wr           (dc_wr),
      .dc_wdata        (dc_wdata),
      .dc_rdata        (dc_rdata),
      .dc_waitrequest  (dc_waitrequest),
      .mem_addr        (mem_addr),
      .mem_rd          (mem_rd),
      .mem_wr          (mem_wr),
      .mem_wdata       (mem_wdata),
      .mem_waitrequest (mem_waitrequest),
      .mem_rdata       (mem_rdata),
      .mem_rdvalid     (mem_rdvalid)
   );

   task automatic check(input string tag, input logic [DW-1:0] got,
                        input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   always @(negedge clock)
      if (reset_n)
         assert (!(dc_rd && dc_wr)) else $error("dc_rd with dc_wr");

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle_inputs();
      ic_rd = 1'b0;
      dc_rd = 1'b0;
      dc_wr = 1'b0;
      mem_waitrequest = 1'b0;
      mem_rdvalid = 1'b0;
      mem_rdata = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset_n = 1'b0;
      cyc();
      cyc();
      reset_n = 1'b1;
   endtask

   localparam logic [DW-1:0] D1 = 128'h0123456789ABCDEF0123456789ABCDEF;
   localparam logic [DW-1:0] PA = 128'hA5A5_0001_5A5A_0002_A5A5_0003_5A5A_0004;
   localparam logic [DW-1:0] DX = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
   localparam logic [DW-1:0] DY = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
   localparam logic [DW-1:0] DZ = 128'h0F0F_F0F0_0F0F_F0F0_0F0F_F0F0_0F0F_F0F0;

   // soak state: requesters, reference memory, device memory
   logic [DW-1:0] ref_mem [16];
   logic [DW-1:0] dev_mem [16];
   bit            ic_pend, dc_pend, dc_is_wr, soak_new, rd_busy;
   logic [AW-1:0] ic_a, dc_a;
   logic [DW-1:0] dc_w;
   int            ic_age, dc_age, ic_others, dc_others;
   int            issued, completed, rd_cnt;
   logic [3:0]    rd_line;

   task automatic soak_cycle();
      if (!ic_pend && soak_new && $urandom_range(0, 2) == 0) begin
         ic_pend = 1; ic_a = $urandom_range(0, 255);
         ic_age = 0; ic_others = 0; issued++;
      end
      if (!dc_pend && soak_new && $urandom_range(0, 2) == 0) begin
         dc_pend = 1; dc_a = $urandom_range(0, 255);
         dc_is_wr = 1'($urandom_range(0, 1));
         dc_w = {$urandom, $urandom, $urandom, $urandom};
         dc_age = 0; dc_others = 0; issued++;
      end
      ic_rd    = ic_pend;
      ic_addr  = ic_pend ? ic_a : $urandom;
      dc_rd    = dc_pend && !dc_is_wr;
      dc_wr    = dc_pend && dc_is_wr;
      dc_addr  = dc_pend ? dc_a : $urandom;
      dc_wdata = dc_pend ? dc_w : {4{$urandom}};
      mem_waitrequest = ($urandom_range(0, 2) == 0);
      mem_rdvalid = 1'b0;
      mem_rdata = {4{$urandom}};
      if (rd_busy) begin
         if (rd_cnt == 0) begin
            mem_rdvalid = 1'b1;
            mem_rdata = dev_mem[rd_line];
            rd_busy = 0;
         end else rd_cnt--;
      end
      settle();
      check("mem_excl", mem_rd & mem_wr, 1'b0);
      check("ic_pass", ic_rdata, mem_rdata);
      if ((mem_rd || mem_wr) && !mem_waitrequest) begin
         check("mem_addr_align", mem_addr & ~32'hF0, '0);
         if (mem_wr) dev_mem[mem_addr[7:4]] = mem_wdata;
         else begin
            rd_busy = 1; rd_line = mem_addr[7:4];
            rd_cnt = $urandom_range(0, 3);
         end
      end
      if (!ic_pend) check("ic_idle_wait", ic_waitrequest, 1'b1);
      else if (!ic_waitrequest) begin
         check("ic_data", ic_rdata, ref_mem[ic_a[7:4]]);
         check("ic_starve", ic_others <= 1, 1'b1);
         ic_pend = 0; completed++;
         if (dc_pend) dc_others++;
      end
      if (!dc_pend) check("dc_idle_wait", dc_waitrequest, 1'b1);
      else if (!dc_waitrequest) begin
         if (dc_is_wr) ref_mem[dc_a[7:4]] = dc_w;
         else check("dc_data", dc_rdata, ref_mem[dc_a[7:4]]);
         check("dc_starve", dc_others <= 1, 1'b1);
         dc_pend = 0; completed++;
         if (ic_pend) ic_others++;
      end
      if (ic_pend && ++ic_age > 100) begin
         check("ic_timeout", ic_waitrequest, 1'b0);
         ic_pend = 0;
      end
      if (dc_pend && ++dc_age > 100) begin
         check("dc_timeout", dc_waitrequest, 1'b0);
         dc_pend = 0;
      end
      cyc();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      ic_addr = '0; dc_addr = '0; dc_wdata = '0;
      idle_inputs();
      reset_n = 1'b0;
      cyc();
      cyc();
      check("rst_mem_rd", mem_rd, 1'b0);
      check("rst_mem_wr", mem_wr, 1'b0);
      check("rst_mem_addr", mem_addr, '0);
      check("rst_mem_wdata", mem_wdata, '0);
      check("rst_ic_wait", ic_waitrequest, 1'b1);
      check("rst_dc_wait", dc_waitrequest, 1'b1);
      reset_n = 1'b1;
      cyc();

      // single icache read, rdvalid 3 cycles after acceptance
      ic_addr = 32'h0000_1234; ic_rd = 1'b1; settle();
      check("t1_wait_c0", ic_waitrequest, 1'b1);
      cyc();
      check("t1_mem_rd", mem_rd, 1'b1);
      check("t1_mem_wr", mem_wr, 1'b0);
      check("t1_mem_addr", mem_addr, 32'h0000_1230);
      cyc();
      check("t1_rd_drop", mem_rd, 1'b0);
      cyc();
      check("t1_wait_c3", ic_waitrequest, 1'b1);
      cyc();
      mem_rdvalid = 1'b1; mem_rdata = D1; settle();
      check("t1_done", ic_waitrequest, 1'b0);
      check("t1_rdata", ic_rdata, D1);
      check("t1_dc_wait", dc_waitrequest, 1'b1);
      cyc();
      mem_rdvalid = 1'b0; ic_rd = 1'b0; settle();
      check("t1_one_cycle", ic_waitrequest, 1'b1);

      // contention from reset: DC first, then strict alternation
      do_reset();
      begin
         bit exp_dc = 1'b1;
         bit rv_next = 1'b0;
         int grants = 0;
         req_id_t own = REQ_IC;
         ic_addr = 32'h0000_0104; dc_addr = 32'h0000_0208;
         ic_rd = 1'b1; dc_rd = 1'b1;
         for (int c = 0; c < 80 && grants < 8; c++) begin
            mem_rdvalid = rv_next;
            mem_rdata = {4{32'(c)}};
            rv_next = 1'b0;
            settle();
            if (mem_rdvalid) begin
               check("t2_ic_wait", ic_waitrequest, own == REQ_DC);
               check("t2_dc_wait", dc_waitrequest, own == REQ_IC);
            end
            if (mem_rd) begin
               check("t2_grant", mem_addr,
                     exp_dc ? 32'h0000_0200 : 32'h0000_0100);
               own = exp_dc ? REQ_DC : REQ_IC;
               exp_dc = !exp_dc;
               grants++;
               rv_next = 1'b1;
            end
            cyc();
         end
         check("t2_grant_count", grants, 8);
      end

      // writeback with 5 cycles of backpressure
      do_reset();
      dc_addr = 32'h8000_0040; dc_wdata = PA; dc_wr = 1'b1;
      mem_waitrequest = 1'b1; settle();
      check("t3_wait_c0", dc_waitrequest, 1'b1);
      for (int c = 1; c <= 6; c++) begin
         cyc();
         mem_waitrequest = (c < 6); settle();
         check("t3_mem_wr", mem_wr, 1'b1);
         check("t3_mem_rd", mem_rd, 1'b0);
         check("t3_mem_addr", mem_addr, 32'h8000_0040);
         check("t3_mem_wdata", mem_wdata, PA);
         check("t3_dc_wait", dc_waitrequest, c < 6);
      end
      cyc();
      dc_wr = 1'b0; mem_waitrequest = 1'b0; settle();
      check("t3_wr_drop", mem_wr, 1'b0);
      check("t3_wait_after", dc_waitrequest, 1'b1);

      // fetch redirect: drop ic_rd in RESP, new ic_rd to 0x2000
      do_reset();
      ic_addr = 32'h0000_1000; ic_rd = 1'b1;
      cyc();
      check("t4_mem_rd1", mem_rd, 1'b1);
      cyc();
      ic_rd = 1'b0; settle();
      check("t4_wait_drop", ic_waitrequest, 1'b1);
      cyc();
      ic_rd = 1'b1; ic_addr = 32'h0000_2000; settle();
      check("t4_no_early", mem_rd, 1'b0);
      cyc();
      mem_rdvalid = 1'b1; mem_rdata = DX; settle();
      check("t4_discard", ic_waitrequest, 1'b1);
      check("t4_no_rd_rv", mem_rd, 1'b0);
      cyc();
      mem_rdvalid = 1'b0; settle();
      check("t4_idle_gap", mem_rd, 1'b0);
      cyc();
      check("t4_mem_rd2", mem_rd, 1'b1);
      check("t4_addr2", mem_addr, 32'h0000_2000);
      cyc();
      mem_rdvalid = 1'b1; mem_rdata = DY; settle();
      check("t4_done2", ic_waitrequest, 1'b0);
      check("t4_rdata2", ic_rdata, DY);
      cyc();
      mem_rdvalid = 1'b0; ic_rd = 1'b0;

      // asynchronous reset while in CMD
      do_reset();
      ic_addr = 32'h0000_3008; ic_rd = 1'b1; mem_waitrequest = 1'b1;
      cyc();
      check("t5_mem_rd", mem_rd, 1'b1);
      reset_n = 1'b0; #1;
      check("t5_rst_rd", mem_rd, 1'b0);
      check("t5_rst_ic", ic_waitrequest, 1'b1);
      check("t5_rst_dc", dc_waitrequest, 1'b1);
      check("t5_rst_addr", mem_addr, '0);
      cyc();
      reset_n = 1'b1; mem_waitrequest = 1'b0;
      cyc();
      check("t5_re_rd", mem_rd, 1'b1);
      check("t5_re_addr", mem_addr, 32'h0000_3000);
      cyc();
      mem_rdvalid = 1'b1; mem_rdata = DZ; settle();
      check("t5_done", ic_waitrequest, 1'b0);
      check("t5_rdata", ic_rdata, DZ);
      cyc();
      mem_rdvalid = 1'b0; ic_rd = 1'b0;

      // randomized soak
      do_reset();
      for (int i = 0; i < 16; i++) begin
         ref_mem[i] = {4{32'hC0DE_0000 + 32'(i)}};
         dev_mem[i] = {4{32'hC0DE_0000 + 32'(i)}};
      end
      ic_pend = 0; dc_pend = 0; rd_busy = 0; soak_new = 1;
      issued = 0; completed = 0;
      for (int c = 0; c < 10000; c++) soak_cycle();
      soak_new = 0;
      for (int c = 0; c < 300 && (ic_pend || dc_pend || rd_busy); c++)
         soak_cycle();
      check("soak_complete", completed, issued);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
